// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants, entry types and mask helper for the CDB arbiter
package sys_defs;

  localparam int N            = 2;   // CDB slots per cycle
  localparam int NUM_FU_TOTAL = 6;   // functional-unit requesters
  localparam int TAG_W        = 6;
  localparam int DATA_W       = 32;
  localparam int BMASK_W      = 4;
  localparam int PTR_W        = $clog2(NUM_FU_TOTAL);

  typedef logic [BMASK_W-1:0] B_MASK;
  typedef logic [PTR_W-1:0]   rr_ptr_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    B_MASK             bmask;
  } CDB_ENTRY;

  localparam CDB_ENTRY CDB_ENTRY_EMPTY = '0;

  // True when a result depends on any branch named in the resolve vector
  function automatic logic hits_branch(input B_MASK mask, input B_MASK resolve);
    return |(mask & resolve);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU request, branch resolve and CDB broadcast signals
interface cdb_arbiter_if;
  import sys_defs::*;

  logic [NUM_FU_TOTAL-1:0]         req_valid;
  logic [NUM_FU_TOTAL*TAG_W-1:0]   req_tag;
  logic [NUM_FU_TOTAL*DATA_W-1:0]  req_data;
  logic [NUM_FU_TOTAL*BMASK_W-1:0] req_bmask;
  logic [NUM_FU_TOTAL-1:0]         req_ready;
  logic [BMASK_W-1:0]              b_mm_resolve;
  logic                            b_mm_mispred;
  logic [N*NUM_FU_TOTAL-1:0]       gnt_bus;
  logic [N-1:0]                    cdb_valid;
  logic [N*TAG_W-1:0]              cdb_tag;
  logic [N*DATA_W-1:0]             cdb_data;
  logic [N*BMASK_W-1:0]            cdb_bmask;

  // Execute stage / branch unit side
  modport master (
    output req_valid, req_tag, req_data, req_bmask, b_mm_resolve, b_mm_mispred,
    input  req_ready, gnt_bus, cdb_valid, cdb_tag, cdb_data, cdb_bmask
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_tag, req_data, req_bmask, b_mm_resolve, b_mm_mispred,
    output req_ready, gnt_bus, cdb_valid, cdb_tag, cdb_data, cdb_bmask
  );

endinterface

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// rtl/cdb_arbiter_rr_multi_grant.sv - combinational N-of-NUM_REQ round-robin selector
module rr_multi_grant
  import sys_defs::*;
#(
  parameter int NUM_SLOTS = N,
  parameter int NUM_REQ   = NUM_FU_TOTAL,
  parameter int PW        = PTR_W
) (
  input  logic [NUM_REQ-1:0]           eligible_i,
  input  logic [PW-1:0]                rr_ptr_i,
  output logic [NUM_SLOTS*NUM_REQ-1:0] gnt_bus_o,
  output logic [PW-1:0]                next_ptr_o
);

  // Visit requesters in order rr_ptr, rr_ptr+1, ... (wrapping) and hand each
  // eligible one the next free slot; the pointer follows the last one served.
  always_comb begin
    logic [PW:0] cand;
    int          taken;
    gnt_bus_o  = '0;
    next_ptr_o = rr_ptr_i;
    cand       = '0;
    taken      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == (PW+1)'(i) && eligible_i[i] && taken < NUM_SLOTS) begin
          for (int s = 0; s < NUM_SLOTS; s++) begin
            if (s == taken) begin
              gnt_bus_o[s*NUM_REQ + i] = 1'b1;
            end
          end
          next_ptr_o = (i == NUM_REQ-1) ? '0 : PW'(i + 1);
          taken      = taken + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result buffers, round-robin CDB grant and registered broadcast
module cdb_arbiter
  import sys_defs::*;
(
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  CDB_ENTRY buf_q    [NUM_FU_TOTAL];
  CDB_ENTRY buf_d    [NUM_FU_TOTAL];
  CDB_ENTRY req_entry[NUM_FU_TOTAL];
  CDB_ENTRY cdb_q    [N];
  CDB_ENTRY cdb_d    [N];
  rr_ptr_t  rr_ptr_q;
  rr_ptr_t  rr_ptr_d;

  logic                      mispred_active;
  logic [NUM_FU_TOTAL-1:0]   buf_valid;
  logic [NUM_FU_TOTAL-1:0]   squash;
  logic [NUM_FU_TOTAL-1:0]   eligible;
  logic [NUM_FU_TOTAL-1:0]   granted;
  logic [NUM_FU_TOTAL-1:0]   ready_vec;
  logic [NUM_FU_TOTAL-1:0]   accept;
  logic [N*NUM_FU_TOTAL-1:0] gnt_raw;

  logic [N-1:0]         cdb_valid_flat;
  logic [N*TAG_W-1:0]   cdb_tag_flat;
  logic [N*DATA_W-1:0]  cdb_data_flat;
  logic [N*BMASK_W-1:0] cdb_bmask_flat;

  assign mispred_active = bus.b_mm_mispred & (|bus.b_mm_resolve);

  // Unpack the flat request bus into one entry per FU (mask as presented)
  always_comb begin
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      req_entry[i].valid = 1'b1;
      req_entry[i].tag   = bus.req_tag[i*TAG_W +: TAG_W];
      req_entry[i].data  = bus.req_data[i*DATA_W +: DATA_W];
      req_entry[i].bmask = bus.req_bmask[i*BMASK_W +: BMASK_W];
    end
  end

  // A mispredicted branch kills dependent buffers before they can compete
  always_comb begin
    buf_valid = '0;
    squash    = '0;
    eligible  = '0;
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      buf_valid[i] = buf_q[i].valid;
      squash[i]    = buf_q[i].valid & mispred_active &
                     hits_branch(buf_q[i].bmask, bus.b_mm_resolve);
      eligible[i]  = buf_q[i].valid & ~squash[i];
    end
  end

  rr_multi_grant #(
    .NUM_SLOTS (N),
    .NUM_REQ   (NUM_FU_TOTAL),
    .PW        (PTR_W)
  ) u_rr_multi_grant (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_bus_o  (gnt_raw),
    .next_ptr_o (rr_ptr_d)
  );

  // Per-FU view of the grants; a buffer being drained this cycle may refill
  always_comb begin
    granted = '0;
    for (int s = 0; s < N; s++) begin
      granted = granted | gnt_raw[s*NUM_FU_TOTAL +: NUM_FU_TOTAL];
    end
    ready_vec = ~buf_valid | granted;
    accept    = bus.req_valid & ready_vec;
  end

  // Buffer next state. Resolve bits are always stripped: on a correct
  // prediction that is the required cleanup, and on a mispredict every
  // survivor already has the bit clear.
  always_comb begin
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      buf_d[i]       = buf_q[i];
      buf_d[i].bmask = buf_q[i].bmask & ~bus.b_mm_resolve;
      if (accept[i]) begin
        buf_d[i]       = req_entry[i];
        buf_d[i].bmask = req_entry[i].bmask & ~bus.b_mm_resolve;
        if (mispred_active && hits_branch(req_entry[i].bmask, bus.b_mm_resolve)) begin
          buf_d[i].valid = 1'b0;
        end
      end else if (granted[i] || squash[i]) begin
        buf_d[i] = CDB_ENTRY_EMPTY;
      end
    end
  end

  // Each CDB slot captures the entry its grant selects; ungranted slots go empty
  always_comb begin
    for (int s = 0; s < N; s++) begin
      cdb_d[s] = CDB_ENTRY_EMPTY;
      for (int i = 0; i < NUM_FU_TOTAL; i++) begin
        if (gnt_raw[s*NUM_FU_TOTAL + i]) begin
          cdb_d[s]       = buf_q[i];
          cdb_d[s].bmask = buf_q[i].bmask & ~bus.b_mm_resolve;
        end
      end
    end
  end

  // State registers; reset discards everything buffered or in broadcast
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU_TOTAL; i++) begin
        buf_q[i] <= CDB_ENTRY_EMPTY;
      end
      for (int s = 0; s < N; s++) begin
        cdb_q[s] <= CDB_ENTRY_EMPTY;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU_TOTAL; i++) begin
        buf_q[i] <= buf_d[i];
      end
      for (int s = 0; s < N; s++) begin
        cdb_q[s] <= cdb_d[s];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Flatten the slot registers onto the broadcast bus
  always_comb begin
    cdb_valid_flat = '0;
    cdb_tag_flat   = '0;
    cdb_data_flat  = '0;
    cdb_bmask_flat = '0;
    for (int s = 0; s < N; s++) begin
      cdb_valid_flat[s]                   = cdb_q[s].valid;
      cdb_tag_flat[s*TAG_W +: TAG_W]       = cdb_q[s].tag;
      cdb_data_flat[s*DATA_W +: DATA_W]    = cdb_q[s].data;
      cdb_bmask_flat[s*BMASK_W +: BMASK_W] = cdb_q[s].bmask;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.gnt_bus   = reset ? '0 : gnt_raw;
  assign bus.cdb_valid = cdb_valid_flat;
  assign bus.cdb_tag   = cdb_tag_flat;
  assign bus.cdb_data  = cdb_data_flat;
  assign bus.cdb_bmask = cdb_bmask_flat;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
  import sys_defs::*;

  localparam int NR = NUM_FU_TOTAL;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Model: what each FU buffer holds, the scan start, and what the CDB shows
  bit               m_v [NR];
  logic [TAG_W-1:0] m_t [NR];
  logic [31:0]      m_d [NR];
  logic [3:0]       m_b [NR];
  int               m_ptr;
  bit               c_v [N];
  logic [TAG_W-1:0] c_t [N];
  logic [31:0]      c_d [N];
  logic [3:0]       c_b [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_v[i] = 0; m_t[i] = '0; m_d[i] = '0; m_b[i] = '0;
    end
    for (int s = 0; s < N; s++) begin
      c_v[s] = 0; c_t[s] = '0; c_d[s] = '0; c_b[s] = '0;
    end
    m_ptr = 0;
  endtask

  task automatic idle();
    bus.req_valid    = '0;
    bus.req_tag      = '0;
    bus.req_data     = '0;
    bus.req_bmask    = '0;
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
  endtask

  task automatic drive_fu(input int i, input logic [TAG_W-1:0] t, input logic [31:0] d,
                          input logic [3:0] b);
    bus.req_valid[i]                  = 1'b1;
    bus.req_tag[i*TAG_W +: TAG_W]     = t;
    bus.req_data[i*DATA_W +: DATA_W]  = d;
    bus.req_bmask[i*BMASK_W +: BMASK_W] = b;
  endtask

  // Compare DUT against the model for the current cycle, then advance both one edge
  task automatic tick();
    int               gl[$];
    bit               gsel [NR];
    logic [N*NR-1:0]  eg;
    logic [NR-1:0]    er;
    logic [3:0]       res;
    logic [3:0]       rb;
    bit               kill;
    bit               n_v [NR];
    logic [TAG_W-1:0] n_t [NR];
    logic [31:0]      n_d [NR];
    logic [3:0]       n_b [NR];
    #1;
    res  = bus.b_mm_resolve;
    kill = bus.b_mm_mispred && (res != 0);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (m_v[i] && !(kill && (m_b[i] & res) != 0) && gl.size() < N) gl.push_back(i);
    end
    eg = '0;
    for (int i = 0; i < NR; i++) gsel[i] = 0;
    foreach (gl[s]) begin
      eg[s*NR + gl[s]] = 1'b1;
      gsel[gl[s]] = 1;
    end
    for (int i = 0; i < NR; i++) er[i] = !m_v[i] || gsel[i];
    chk("gnt_bus", bus.gnt_bus, eg);
    chk("req_ready", bus.req_ready, er);
    for (int s = 0; s < N; s++) begin
      chk("cdb_valid", bus.cdb_valid[s], c_v[s]);
      if (c_v[s]) begin
        chk("cdb_tag", bus.cdb_tag[s*TAG_W +: TAG_W], c_t[s]);
        chk("cdb_data", bus.cdb_data[s*DATA_W +: DATA_W], c_d[s]);
        chk("cdb_bmask", bus.cdb_bmask[s*BMASK_W +: BMASK_W], c_b[s]);
      end
    end
    for (int i = 0; i < NR; i++) begin
      n_v[i] = m_v[i] && !gsel[i] && !(kill && (m_b[i] & res) != 0);
      n_t[i] = m_t[i];
      n_d[i] = m_d[i];
      n_b[i] = kill ? m_b[i] : (m_b[i] & ~res);
      if (bus.req_valid[i] && er[i]) begin
        rb = bus.req_bmask[i*BMASK_W +: BMASK_W];
        if (kill && (rb & res) != 0) begin
          n_v[i] = 0;
        end else begin
          n_v[i] = 1;
          n_t[i] = bus.req_tag[i*TAG_W +: TAG_W];
          n_d[i] = bus.req_data[i*DATA_W +: DATA_W];
          n_b[i] = kill ? rb : (rb & ~res);
        end
      end
    end
    @(posedge clock);
    for (int s = 0; s < N; s++) begin
      c_v[s] = s < gl.size();
      if (s < gl.size()) begin
        c_t[s] = m_t[gl[s]];
        c_d[s] = m_d[gl[s]];
        c_b[s] = kill ? m_b[gl[s]] : (m_b[gl[s]] & ~res);
      end
    end
    if (gl.size() > 0) m_ptr = (gl[gl.size()-1] + 1) % NR;
    for (int i = 0; i < NR; i++) begin
      m_v[i] = n_v[i]; m_t[i] = n_t[i]; m_d[i] = n_d[i]; m_b[i] = n_b[i];
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*NR-1:0] fair_gnt [4];
    logic [NR-1:0]   fair_rdy [4];
    fair_gnt = '{12'h081, 12'h204, 12'h810, 12'h081};
    fair_rdy = '{6'h03, 6'h0c, 6'h30, 6'h03};

    idle();
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("reset_cdb_valid", bus.cdb_valid, 2'b00);
    chk("reset_gnt", bus.gnt_bus, '0);
    chk("reset_ready", bus.req_ready, 6'h3f);
    reset = 1'b0;
    @(negedge clock);

    // Single result: two-cycle latency to the CDB
    drive_fu(2, 6'd5, 32'hDEAD, 4'b0000);
    tick();
    idle();
    #1 chk("single_gnt", bus.gnt_bus, 12'h004);
    tick();
    #1 chk("single_cdb_valid", bus.cdb_valid, 2'b01);
    chk("single_cdb_tag", bus.cdb_tag[TAG_W-1:0], 6'd5);
    chk("single_cdb_data", bus.cdb_data[DATA_W-1:0], 32'hDEAD);
    tick();

    // Three-way contention
    do_reset();
    drive_fu(0, 6'd1, 32'h10, 4'b0000);
    drive_fu(3, 6'd2, 32'h13, 4'b0000);
    drive_fu(4, 6'd3, 32'h14, 4'b0000);
    tick();
    idle();
    #1 chk("contend_gnt0", bus.gnt_bus, 12'h201);
    tick();
    #1 chk("contend_gnt1", bus.gnt_bus, 12'h010);
    tick();

    // Fairness with wrap: everyone requests every cycle
    do_reset();
    for (int i = 0; i < NR; i++) drive_fu(i, TAG_W'(i + 1), 32'(i), 4'b0000);
    tick();
    for (int j = 0; j < 4; j++) begin
      #1 chk("fair_gnt", bus.gnt_bus, fair_gnt[j]);
      chk("fair_ready", bus.req_ready, fair_rdy[j]);
      tick();
    end

    // Backpressure on FU1 until it is granted
    do_reset();
    drive_fu(2, 6'd1, 32'h12, 4'b0000);
    tick();
    idle();
    tick();
    drive_fu(3, 6'd2, 32'h23, 4'b0000);
    drive_fu(4, 6'd3, 32'h34, 4'b0000);
    drive_fu(1, 6'd7, 32'h77, 4'b0000);
    tick();
    idle();
    drive_fu(1, 6'd9, 32'h99, 4'b0000);
    #1 chk("bp_gnt", bus.gnt_bus, 12'h408);
    chk("bp_ready_low", bus.req_ready[1], 1'b0);
    tick();
    #1 chk("bp_gnt_fu1", bus.gnt_bus, 12'h002);
    chk("bp_ready_high", bus.req_ready[1], 1'b1);
    tick();
    idle();
    #1 chk("bp_old_tag", bus.cdb_tag[TAG_W-1:0], 6'd7);
    chk("bp_new_gnt", bus.gnt_bus, 12'h002);
    tick();
    #1 chk("bp_new_tag", bus.cdb_tag[TAG_W-1:0], 6'd9);
    chk("bp_new_data", bus.cdb_data[DATA_W-1:0], 32'h99);
    tick();

    // Mispredict squash
    do_reset();
    drive_fu(0, 6'd10, 32'hA0, 4'b0010);
    drive_fu(1, 6'd11, 32'hB1, 4'b0000);
    tick();
    idle();
    bus.b_mm_resolve = 4'b0010;
    bus.b_mm_mispred = 1'b1;
    #1 chk("squash_gnt", bus.gnt_bus, 12'h002);
    tick();
    idle();
    #1 chk("squash_cdb_valid", bus.cdb_valid, 2'b01);
    chk("squash_cdb_tag", bus.cdb_tag[TAG_W-1:0], 6'd11);
    chk("squash_gone", bus.gnt_bus, '0);
    tick();

    // Correct prediction clears the bit, then reset mid-broadcast
    do_reset();
    drive_fu(0, 6'd10, 32'hA0, 4'b0010);
    drive_fu(1, 6'd11, 32'hB1, 4'b0000);
    tick();
    idle();
    bus.b_mm_resolve = 4'b0010;
    bus.b_mm_mispred = 1'b0;
    #1 chk("correct_gnt", bus.gnt_bus, 12'h081);
    tick();
    idle();
    #1 chk("correct_cdb_valid", bus.cdb_valid, 2'b11);
    chk("correct_cdb_tag", bus.cdb_tag[TAG_W-1:0], 6'd10);
    chk("correct_cdb_bmask", bus.cdb_bmask[BMASK_W-1:0], 4'b0000);
    reset = 1'b1;
    #1 chk("async_cdb_valid", bus.cdb_valid, 2'b00);
    chk("async_ready", bus.req_ready, 6'h3f);
    chk("async_gnt", bus.gnt_bus, '0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) drive_fu(i, TAG_W'(i + 20), 32'(i + 100), 4'b0000);
    tick();
    idle();
    #1 chk("post_reset_gnt", bus.gnt_bus, 12'h081);
    tick();

    // Random traffic with branch resolves against the model
    repeat (400) begin
      idle();
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 1) == 1)
          drive_fu(i, TAG_W'($urandom), $urandom,
                   ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.b_mm_resolve = 4'b0001 << $urandom_range(0, 3);
        bus.b_mm_mispred = 1'($urandom_range(0, 1));
      end
      tick();
    end
    idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
